alu_iter: RTL and testbench
===========================

# alu_iter

Multi-cycle execution unit that consumes the 4-bit ALU control code produced by the ALU decoder and executes it on two WIDTH-bit operands. It sits in the execute stage of the multi-cycle core:
- Logic and arithmetic ops complete in one cycle.
- Shifts run serially at one bit per cycle to save area.
- A valid/ready handshake on each side lets the controller stall until `out_valid`.

## Interface
- `WIDTH`, default 32: operand/result width; must be a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on rising edge of `clk`.
- `in_valid` input 1: operands and code valid.
- `in_ready` output 1: unit can accept; high only in IDLE.
- `a` input WIDTH: operand A (SrcA).
- `b` input WIDTH: operand B (SrcB); `b[SHW-1:0]` is the shift amount.
- `alu_control` input 4: operation code.
- `out_valid` output 1: result and flags valid.
- `out_ready` input 1: consumer accepts result.
- `result` output WIDTH: operation result.
- `zero` output 1: result == 0.
- `neg` output 1: `result[WIDTH-1]`.
- `carry` output 1: carry out (ADD) / no-borrow (SUB); 0 for other ops.
- `overflow` output 1: signed overflow (ADD/SUB); 0 for other ops.
- `busy` output 1: state != IDLE.

## Operation
Codes:
- 0000 ADD: a+b.
- 0001 SUB: a+~b+1.
- 0010 AND.
- 0011 OR.
- 0100 XOR.
- 0101 SLT: signed a<b → 1, else 0.
- 0110 SLTU: unsigned.
- 1000 SLL.
- 1001 SRL: zero fill.
- 1010 SRA: sign fill.
- Any other code: result 0, all flags computed from 0 (zero=1).

Arithmetic rules:
- All arithmetic is modulo 2^WIDTH.
- SLT = (a-b) sign XOR signed overflow.
- SLTU = NOT carry of a+~b+1.
- Only `b[SHW-1:0]` is used as shamt; upper bits of b are ignored.

State machine (IDLE, EXEC, SHIFT, DONE):
- IDLE → EXEC on `in_valid && in_ready`. Latch `a`, `b`, `alu_control` into internal registers; later input changes are ignored.
- EXEC, non-shift code → DONE. Compute the result and flags combinationally from the latched operands and register them.
- EXEC, shift code with shamt=0 → DONE, result = a.
- EXEC, shift code with shamt=k>0 → SHIFT. Load the working register with a and the counter with k.
- SHIFT: each cycle, shift the working register by 1 bit (direction/fill per code) and decrement the counter. On the cycle the counter reaches 0, register the result and go to DONE.
- DONE: `out_valid`=1; result and flags held stable until `out_ready`. On `out_ready` → IDLE.

Flags: `zero` and `neg` derive from the final result for every op. `carry` and `overflow` are nonzero only for codes 0000/0001.

Reset:
- Any state → IDLE.
- `result`=0, `zero`=0, `neg`=0, `carry`=0, `overflow`=0, `out_valid`=0, `busy`=0, `in_ready`=1 (first cycle after reset).
- Reset mid-shift or in DONE discards the operation; no `out_valid` pulse.

## Timing
- Accept in cycle N (`in_valid && in_ready` at edge N).
- Non-shift op: `out_valid` from cycle N+1.
- Shift with shamt k: `out_valid` from cycle N+1+k (k=0 → N+1; k=WIDTH-1 → N+WIDTH).
- Result transfer on an edge with `out_valid && out_ready`. `in_ready` rises the following cycle.
- Back-to-back non-shift ops with `out_ready` tied high: one accept every 3 cycles (IDLE, EXEC, DONE).
- `in_ready` is a registered function of state only; no combinational path from `out_ready` or `in_valid` to `in_ready`.
- Stall in DONE is unbounded; outputs are held stable throughout.
- `in_valid` while busy is ignored; no input is queued.

## Test plan
- Reset, then ADD a=0x7FFFFFFF b=0x00000001 → `out_valid` at N+1, result 0x80000000, neg=1, overflow=1, carry=0, zero=0.
- SUB a=5 b=5 → result 0, zero=1, carry=1. SLT a=0xFFFFFFFF b=1 → 1. SLTU with the same operands → 0.
- SRA a=0x80000000 b=0x0000001F (shamt 31) → `out_valid` at N+32, result 0xFFFFFFFF. SRL with the same operands → 0x00000001. SLL a=1 b=0x20 (shamt 0) → `out_valid` at N+1, result 1.
- SLL a=3 b=4, with `out_ready` held low for 10 cycles after `out_valid` → result 0x30 held stable. `in_valid` pulses during the stall are ignored, and `in_ready` stays 0 until after the transfer.
- Reset asserted during a shift of 20 → next cycle IDLE, all outputs 0, `in_ready`=1. A following AND 0xF0F0 & 0xFF00 → 0xF000.
- Illegal code 0111 → result 0, zero=1, carry=0, overflow=0. Random ADD/SUB/logic sequence checked against a reference model with random `out_ready` backpressure.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle execute unit. Logic and arithmetic codes finish in one
// EXEC cycle. Shifts run serially, one bit per cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE. out_valid is high only in DONE. Both are
// registered and depend on state alone. The result and the flags stay stable
// for the whole time out_valid is high.
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       code_r;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_v;
  logic             sub_v;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             is_shift;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] work_sh;

  assign dbg_state = state;
  assign shamt     = b_r[SHW-1:0];
  assign is_shift  = (code_r == OP_SLL) || (code_r == OP_SRL) || (code_r == OP_SRA);

  // Single-cycle ALU on the latched operands. SLT and SLTU reuse the subtractor.
  always_comb begin
    add_full = {1'b0, a_r} + {1'b0, b_r};
    sub_full = {1'b0, a_r} + {1'b0, ~b_r} + {{WIDTH{1'b0}}, 1'b1};
    add_v    = (a_r[MSB] == b_r[MSB]) && (add_full[MSB] != a_r[MSB]);
    sub_v    = (a_r[MSB] != b_r[MSB]) && (sub_full[MSB] != a_r[MSB]);
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (code_r)
      OP_ADD:  begin alu_res = add_full[MSB:0]; alu_c = add_full[WIDTH]; alu_v = add_v; end
      OP_SUB:  begin alu_res = sub_full[MSB:0]; alu_c = sub_full[WIDTH]; alu_v = sub_v; end
      OP_AND:  alu_res = a_r & b_r;
      OP_OR:   alu_res = a_r | b_r;
      OP_XOR:  alu_res = a_r ^ b_r;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sub_full[MSB] ^ sub_v};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
      default: alu_res = '0;
    endcase
  end

  // Shift the working register by one bit, using the direction and fill that the latched code selects.
  always_comb begin
    work_sh = work;
    case (code_r)
      OP_SLL:  work_sh = {work[MSB-1:0], 1'b0};
      OP_SRL:  work_sh = {1'b0, work[MSB:1]};
      OP_SRA:  work_sh = {work[MSB], work[MSB:1]};
      default: work_sh = work;
    endcase
  end

  // Control FSM. This block also holds the operand registers and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      code_r    <= '0;
      work      <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            code_r   <= alu_control;
            state    <= EXEC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        EXEC: begin
          if (is_shift && (shamt != '0)) begin
            work  <= a_r;
            cnt   <= shamt;
            state <= SHIFT;
          end else if (is_shift) begin
            result    <= a_r;
            zero      <= (a_r == '0);
            neg       <= a_r[MSB];
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            neg       <= alu_res[MSB];
            carry     <= alu_c;
            overflow  <= alu_v;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        SHIFT: begin
          work <= work_sh;
          cnt  <= cnt - {{(SHW-1){1'b0}}, 1'b1};
          if (cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
            result    <= work_sh;
            zero      <= (work_sh == '0);
            neg       <= work_sh[MSB];
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter. It checks reset values, each op class, shift
// latency, stalls in DONE, and reset in the middle of a shift. It ends with a
// model-checked random sequence of arithmetic and logic ops under backpressure.
module tb_alu_iter;

  localparam int W  = 32;
  localparam int EW = W + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    alu_control = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          zero, neg, carry, overflow, busy;
  logic [1:0]    dbg_state;

  int nvec = 0;
  int nerr = 0;
  int lat;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] expv;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .neg(neg),
    .carry(carry), .overflow(overflow), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] r, input logic z,
                         input logic n, input logic c, input logic v);
    chk({tag, ".result"}, result, r);
    chk({tag, ".flags"}, {28'd0, zero, neg, carry, overflow}, {28'd0, z, n, c, v});
  endtask

  // driver: wait (bounded) for in_ready, then present one op for one edge
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [3:0] op);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    a = av; b = bv; alu_control = op; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; alu_control = 4'($urandom_range(0, 15));
  endtask

  // count edges after the accept edge until out_valid is seen (bounded)
  task automatic wait_valid(output int l);
    l = 0;
    while (!out_valid && l < 100) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  // one-edge result transfer; in_ready must rise right after it
  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".in_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".out_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  // reference model: {result, zero, neg, carry, overflow}
  function automatic logic [EW-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [3:0] op);
    logic [W-1:0] r;
    logic         c, v;
    longint       sx, sy, s;
    r = '0; c = 1'b0; v = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      4'd0: begin r = x + y; c = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
              s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin r = x - y; c = (x >= y);
              s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd6: r = (x < y) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {r, (r == '0), r[W-1], c, v};
  endfunction

  initial begin
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset.result", result, 32'd0);
    chk("reset.flags", {28'd0, zero, neg, carry, overflow}, 32'd0);
    chk("reset.hs", {29'd0, out_valid, busy, in_ready}, 32'd1);
    chk("reset.state", {30'd0, dbg_state}, 32'd0);

    // ADD with signed overflow
    send(32'h7FFF_FFFF, 32'h0000_0001, 4'b0000);
    chk("add.busy", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    chk("add.lat", lat, 32'd1);
    chk_out("add", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    take("add");

    // SUB equal operands
    send(32'd5, 32'd5, 4'b0001);
    wait_valid(lat);
    chk("sub.lat", lat, 32'd1);
    chk_out("sub", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    take("sub");

    // SLT / SLTU on -1 vs 1
    send(32'hFFFF_FFFF, 32'd1, 4'b0101);
    wait_valid(lat);
    chk_out("slt", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    take("slt");
    send(32'hFFFF_FFFF, 32'd1, 4'b0110);
    wait_valid(lat);
    chk_out("sltu", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    take("sltu");

    // SRA / SRL by 31: latency 32
    send(32'h8000_0000, 32'h0000_001F, 4'b1010);
    wait_valid(lat);
    chk("sra.lat", lat, 32'd32);
    chk_out("sra", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    take("sra");
    send(32'h8000_0000, 32'h0000_001F, 4'b1001);
    wait_valid(lat);
    chk("srl.lat", lat, 32'd32);
    chk_out("srl", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    take("srl");

    // SLL with b=0x20: shamt bits are zero, upper bits ignored
    send(32'd1, 32'h0000_0020, 4'b1000);
    wait_valid(lat);
    chk("sll0.lat", lat, 32'd1);
    chk_out("sll0", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    take("sll0");

    // SLL 3<<4 with a 10-cycle stall, in_valid pulses ignored
    send(32'd3, 32'd4, 4'b1000);
    wait_valid(lat);
    chk("stall.lat", lat, 32'd5);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 32'hDEAD_BEEF; b = 32'd1; alu_control = 4'b0000;
      @(posedge clk);
      @(negedge clk);
      chk("stall.result", result, 32'h30);
      chk("stall.hs", {29'd0, out_valid, busy, in_ready}, 32'b110);
    end
    in_valid = 1'b0;
    take("stall");
    repeat (3) @(negedge clk);
    chk("stall.no_queue", {30'd0, out_valid, busy}, 32'd0);

    // reset during a 20-bit shift
    send(32'd1, 32'd20, 4'b1000);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid.result", result, 32'd0);
    chk("rst_mid.flags", {28'd0, zero, neg, carry, overflow}, 32'd0);
    chk("rst_mid.hs", {29'd0, out_valid, busy, in_ready}, 32'd1);
    repeat (25) @(negedge clk);
    chk("rst_mid.no_pulse", {31'd0, out_valid}, 32'd0);
    send(32'h0000_F0F0, 32'h0000_FF00, 4'b0010);
    wait_valid(lat);
    chk_out("and", 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
    take("and");

    // illegal codes
    send(32'h1234_5678, 32'hFFFF_FFFF, 4'b0111);
    wait_valid(lat);
    chk_out("ill7", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    take("ill7");
    send(32'hFFFF_FFFF, 32'd1, 4'b1111);
    wait_valid(lat);
    chk_out("illF", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    take("illF");

    // random arithmetic/logic with random backpressure
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic [3:0]   rop;
      int           hold;
      ra  = $urandom;
      rb  = (i % 5 == 0) ? ra : $urandom;
      if (i % 7 == 0) ra = 32'h8000_0000;
      rop = 4'($urandom_range(0, 6));
      exp_q.push_back(ref_op(ra, rb, rop));
      send(ra, rb, rop);
      wait_valid(lat);
      chk("rnd.lat", lat, 32'd1);
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        @(negedge clk);
      end
      expv = exp_q.pop_front();
      chk_out("rnd", expv[EW-1:4], expv[3], expv[2], expv[1], expv[0]);
      take("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
